stack_pop_seq: RTL and testbench

- Consumer side of the pre-decode `push`/`pop` register-mask encoding.
- Given a 16-bit pop mask from the decoder, it issues word reads at SS:SP and increments SP by 2 per word.
- Each returned word is delivered to the register file, sysreg or operand path.
- Mask bits are walked in reverse of push order (bit 15 down to bit 0), so `pop` exactly undoes a `push` of the same mask.
- Sits between the execute stage and the bus interface unit.

---
 rtl/stack_pop_seq_pkg.sv | 59 +++++
 rtl/stack_prio_msb.sv | 25 ++
 rtl/stack_pop_seq.sv | 174 +++++++++++++++++
 tb/tb_stack_pop_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pop_seq_pkg.sv
// Shared definitions for the stack pop sequencer (and its push counterpart):
// STACK_* register-mask bit positions and masks, the pop FSM state type and
// the segment:offset to physical address helper.
package stack_pop_seq_pkg;

   // Bit positions of each destination inside the 16-bit stack mask.
   // Pops walk from bit 15 down to bit 0; pushes walk the other way.
   localparam logic [3:0] STACK_IDX_AW         = 4'd0;
   localparam logic [3:0] STACK_IDX_CW         = 4'd1;
   localparam logic [3:0] STACK_IDX_DW         = 4'd2;
   localparam logic [3:0] STACK_IDX_BW         = 4'd3;
   localparam logic [3:0] STACK_IDX_SP         = 4'd4;
   localparam logic [3:0] STACK_IDX_SP_DISCARD = 4'd5;
   localparam logic [3:0] STACK_IDX_BP         = 4'd6;
   localparam logic [3:0] STACK_IDX_IX         = 4'd7;
   localparam logic [3:0] STACK_IDX_IY         = 4'd8;
   localparam logic [3:0] STACK_IDX_DS1        = 4'd9;
   localparam logic [3:0] STACK_IDX_PSW        = 4'd10;
   localparam logic [3:0] STACK_IDX_PS         = 4'd11;
   localparam logic [3:0] STACK_IDX_SS         = 4'd12;
   localparam logic [3:0] STACK_IDX_DS0        = 4'd13;
   localparam logic [3:0] STACK_IDX_PC         = 4'd14;
   localparam logic [3:0] STACK_IDX_OPERAND    = 4'd15;

   // One-hot masks as emitted by the pre-decoder.
   localparam logic [15:0] STACK_AW         = 16'h0001;
   localparam logic [15:0] STACK_CW         = 16'h0002;
   localparam logic [15:0] STACK_DW         = 16'h0004;
   localparam logic [15:0] STACK_BW         = 16'h0008;
   localparam logic [15:0] STACK_SP         = 16'h0010;
   localparam logic [15:0] STACK_SP_DISCARD = 16'h0020;
   localparam logic [15:0] STACK_BP         = 16'h0040;
   localparam logic [15:0] STACK_IX         = 16'h0080;
   localparam logic [15:0] STACK_IY         = 16'h0100;
   localparam logic [15:0] STACK_DS1        = 16'h0200;
   localparam logic [15:0] STACK_PSW        = 16'h0400;
   localparam logic [15:0] STACK_PS         = 16'h0800;
   localparam logic [15:0] STACK_SS         = 16'h1000;
   localparam logic [15:0] STACK_DS0        = 16'h2000;
   localparam logic [15:0] STACK_PC         = 16'h4000;
   localparam logic [15:0] STACK_OPERAND    = 16'h8000;

   // Pop sequencer states.
   typedef enum logic [2:0] {
      POP_IDLE   = 3'd0,
      POP_SCAN   = 3'd1,
      POP_READ   = 3'd2,
      POP_WRITE  = 3'd3,
      POP_FINISH = 3'd4
   } pop_state_e;

   // Segment:offset to physical address at full precision; callers truncate
   // to their address width, which gives the modulo wrap.
   function automatic logic [31:0] seg_phys_addr(input logic [15:0] seg,
                                                 input logic [15:0] off);
      return {12'b0, seg, 4'b0} + {16'b0, off};
   endfunction

endpackage

// File: rtl/stack_prio_msb.sv
// Combinational highest-set-bit encoder. Reports the index of the most
// significant set bit and a flag when the vector is all zero. The push
// sequencer reuses it by feeding a bit-reversed mask.
module stack_prio_msb #(
   parameter int W     = 16,
   parameter int IDX_W = 4
) (
   input  logic [W-1:0]     i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_zero
);

   // Scan upward so the last hit, the highest set bit, wins.
   always_comb begin
      o_idx  = '0;
      o_zero = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (i_vec[i]) begin
            o_idx  = i[IDX_W-1:0];
            o_zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/stack_pop_seq.sv
// Stack pop sequencer: walks a STACK_* mask from bit 15 down to bit 0,
// reads one word per set bit at SS:SP, bumps SP by 2 per word and hands
// each word to the register file. Popping SP reloads the working SP,
// popping SS reloads the working SS, and SP_DISCARD reads but drops.
// Optional build macro STACK_POP_ABORT_EN adds an abort input that
// cancels a running sequence without any SP writeback or done pulse.
module stack_pop_seq
   import stack_pop_seq_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int MASK_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
`ifdef STACK_POP_ABORT_EN
   input  logic              abort,
`endif
   input  logic [MASK_W-1:0] pop_mask,
   input  logic [15:0]       ss,
   input  logic [15:0]       sp,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic              wr_valid,
   output logic [3:0]        wr_index,
   output logic [15:0]       wr_data,
   output logic              sp_wr,
   output logic [15:0]       sp_next,
   output logic              busy,
   output logic              done
);

   pop_state_e        r_state;
   pop_state_e        w_next;
   logic [MASK_W-1:0] r_mask;
   logic [15:0]       r_ss;
   logic [15:0]       r_sp;
   logic [3:0]        r_idx;
   logic [15:0]       r_data;
   logic [3:0]        w_selIdx;
   logic              w_maskZero;
   logic              w_abort;

   stack_prio_msb #(
      .W     (MASK_W),
      .IDX_W (4)
   ) u_prio (
      .i_vec  (r_mask),
      .o_idx  (w_selIdx),
      .o_zero (w_maskZero)
   );

`ifdef STACK_POP_ABORT_EN
   assign w_abort = abort && (r_state != POP_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   // State register; reset drops any outstanding request immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= POP_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and output decode; abort overrides everything it touches.
   always_comb begin
      w_next   = r_state;
      mem_req  = 1'b0;
      mem_addr = '0;
      wr_valid = 1'b0;
      wr_index = 4'd0;
      wr_data  = 16'd0;
      sp_wr    = 1'b0;
      sp_next  = 16'd0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         POP_IDLE: begin
            if (start) begin
               w_next = POP_SCAN;
            end
         end
         POP_SCAN: begin
            busy   = 1'b1;
            w_next = w_maskZero ? POP_FINISH : POP_READ;
         end
         POP_READ: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            mem_addr = ADDR_W'(seg_phys_addr(r_ss, r_sp));
            if (mem_ack) begin
               w_next = POP_WRITE;
            end
         end
         POP_WRITE: begin
            busy     = 1'b1;
            wr_valid = (r_idx != STACK_IDX_SP_DISCARD);
            wr_index = r_idx;
            wr_data  = r_data;
            w_next   = POP_SCAN;
         end
         POP_FINISH: begin
            sp_wr   = 1'b1;
            sp_next = r_sp;
            done    = 1'b1;
            w_next  = POP_IDLE;
         end
         default: begin
            w_next = POP_IDLE;
         end
      endcase
      if (w_abort) begin
         w_next   = POP_IDLE;
         mem_req  = 1'b0;
         mem_addr = '0;
         wr_valid = 1'b0;
         wr_index = 4'd0;
         wr_data  = 16'd0;
         sp_wr    = 1'b0;
         sp_next  = 16'd0;
         done     = 1'b0;
      end
   end

   // Working registers: capture on start, select in SCAN, advance SP on
   // each accepted read, and retire the selected bit in WRITE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask <= '0;
         r_ss   <= 16'd0;
         r_sp   <= 16'd0;
         r_idx  <= 4'd0;
         r_data <= 16'd0;
      end else begin
         case (r_state)
            POP_IDLE: begin
               if (start) begin
                  r_mask <= pop_mask;
                  r_ss   <= ss;
                  r_sp   <= sp;
               end
            end
            POP_SCAN: begin
               r_idx <= w_selIdx;
            end
            POP_READ: begin
               if (mem_ack && !w_abort) begin
                  r_data <= mem_rdata;
                  r_sp   <= r_sp + 16'd2;
               end
            end
            POP_WRITE: begin
               if (!w_abort) begin
                  r_mask[r_idx] <= 1'b0;
                  if (r_idx == STACK_IDX_SP) begin
                     r_sp <= r_data;
                  end
                  if (r_idx == STACK_IDX_SS) begin
                     r_ss <= r_data;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_pop_seq.sv
// Scoreboard bench for stack_pop_seq: directed sequences push expected read
// addresses, register writes and final SP values into queues; a monitor
// pops and compares whenever the DUT presents them, and a bus responder
// returns queued read data after a programmable wait.
module tb_stack_pop_seq;
   import stack_pop_seq_pkg::*;

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] data;
   } wr_exp_t;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] pop_mask;
   logic [15:0] ss;
   logic [15:0] sp;
   logic        mem_req;
   logic [19:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        wr_valid;
   logic [3:0]  wr_index;
   logic [15:0] wr_data;
   logic        sp_wr;
   logic [15:0] sp_next;
   logic        busy;
   logic        done;
`ifdef STACK_POP_ABORT_EN
   logic        abort;
`endif

   int checks = 0;
   int errors = 0;

   logic [19:0] addrQ[$];
   wr_exp_t     wrQ[$];
   logic [15:0] spQ[$];
   logic [15:0] rdataQ[$];
   int          ackWait = 0;
   int          waitCnt = 0;
   logic        prevReq = 1'b0;

   stack_pop_seq #(
      .ADDR_W (20),
      .MASK_W (16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
`ifdef STACK_POP_ABORT_EN
      .abort     (abort),
`endif
      .pop_mask  (pop_mask),
      .ss        (ss),
      .sp        (sp),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .wr_valid  (wr_valid),
      .wr_index  (wr_index),
      .wr_data   (wr_data),
      .sp_wr     (sp_wr),
      .sp_next   (sp_next),
      .busy      (busy),
      .done      (done)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and tally the result.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Record a DUT output that no expectation was waiting for.
   task automatic reportUnexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected output value=%0h", name, act);
   endtask

   // Monitor: compare every read request, register write and completion.
   always @(negedge clk) begin
      if (!reset_n) begin
         prevReq = 1'b0;
      end else begin
         if (mem_req && !prevReq) begin
            if (addrQ.size() == 0) reportUnexpected("mem_addr", 32'(mem_addr));
            else checkOutput("mem_addr", 32'(mem_addr), 32'(addrQ.pop_front()));
         end
         prevReq = mem_req;
         if (wr_valid) begin
            if (wrQ.size() == 0) begin
               reportUnexpected("wr_index", 32'(wr_index));
            end else begin
               wr_exp_t e;
               e = wrQ.pop_front();
               checkOutput("wr_index", 32'(wr_index), 32'(e.idx));
               checkOutput("wr_data", 32'(wr_data), 32'(e.data));
            end
         end
         if (done) begin
            if (spQ.size() == 0) begin
               reportUnexpected("sp_next", 32'(sp_next));
            end else begin
               checkOutput("sp_next", 32'(sp_next), 32'(spQ.pop_front()));
               checkOutput("sp_wr_with_done", 32'(sp_wr), 32'd1);
               checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
         end else if (sp_wr) begin
            reportUnexpected("sp_wr", 32'(sp_next));
         end
      end
   end

   // Bus responder: acknowledge each request after ackWait cycles.
   always @(negedge clk) begin
      if (!reset_n) begin
         mem_ack = 1'b0;
         waitCnt = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
         waitCnt = 0;
      end else if (mem_req) begin
         if (waitCnt >= ackWait) begin
            mem_ack   = 1'b1;
            mem_rdata = (rdataQ.size() != 0) ? rdataQ.pop_front() : 16'hDEAD;
            waitCnt   = 0;
         end else begin
            waitCnt++;
         end
      end else begin
         waitCnt = 0;
      end
   end

   // Pulse start for one cycle with the given operands.
   task automatic applyStimulus(input logic [15:0] m, input logic [15:0] s,
                                input logic [15:0] p);
      @(negedge clk);
      pop_mask = m;
      ss       = s;
      sp       = p;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Wait (bounded) for done, then confirm every expectation was consumed.
   task automatic waitDone(input string name, input int budget, output int cycles);
      cycles = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         cycles++;
         if (done) break;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout waiting for done after %0d cycles", name, budget);
      end
      #2;
      checkOutput({name, "_reads_left"}, 32'(addrQ.size()), 32'd0);
      checkOutput({name, "_writes_left"}, 32'(wrQ.size()), 32'd0);
      checkOutput({name, "_sp_left"}, 32'(spQ.size()), 32'd0);
   endtask

   task automatic pushWrite(input logic [3:0] i, input logic [15:0] d);
      wr_exp_t e;
      e.idx  = i;
      e.data = d;
      wrQ.push_back(e);
   endtask

   // Watchdog against a hung simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int cyc;
      reset_n   = 1'b0;
      start     = 1'b0;
      pop_mask  = 16'd0;
      ss        = 16'd0;
      sp        = 16'd0;
      mem_ack   = 1'b0;
      mem_rdata = 16'd0;
`ifdef STACK_POP_ABORT_EN
      abort     = 1'b0;
`endif
      #1;
      checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset_wr_valid", 32'(wr_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_sp_wr", 32'(sp_wr), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Single AW pop, zero-wait ack.
      $display("[TB] single AW pop");
      addrQ.push_back(20'h10100);
      rdataQ.push_back(16'h1234);
      pushWrite(STACK_IDX_AW, 16'h1234);
      spQ.push_back(16'h0102);
      applyStimulus(STACK_AW, 16'h1000, 16'h0100);
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      waitDone("aw", 50, cyc);

      // Interrupt frame PC|PS|PSW.
      $display("[TB] interrupt frame pop");
      addrQ.push_back(20'h20200);
      addrQ.push_back(20'h20202);
      addrQ.push_back(20'h20204);
      rdataQ.push_back(16'h0010);
      rdataQ.push_back(16'hF000);
      rdataQ.push_back(16'h0202);
      pushWrite(STACK_IDX_PC, 16'h0010);
      pushWrite(STACK_IDX_PS, 16'hF000);
      pushWrite(STACK_IDX_PSW, 16'h0202);
      spQ.push_back(16'h0206);
      applyStimulus(STACK_PC | STACK_PS | STACK_PSW, 16'h2000, 16'h0200);
      waitDone("iframe", 50, cyc);

      // POP R style mask with SP_DISCARD, plus a start while busy.
      $display("[TB] POP R mask with discard");
      for (int i = 0; i < 8; i++) begin
         addrQ.push_back(20'h30F00 + 20'(2 * i));
         rdataQ.push_back(16'hA000 + 16'(i));
      end
      pushWrite(STACK_IDX_IY, 16'hA000);
      pushWrite(STACK_IDX_IX, 16'hA001);
      pushWrite(STACK_IDX_BP, 16'hA002);
      pushWrite(STACK_IDX_BW, 16'hA004);
      pushWrite(STACK_IDX_DW, 16'hA005);
      pushWrite(STACK_IDX_CW, 16'hA006);
      pushWrite(STACK_IDX_AW, 16'hA007);
      spQ.push_back(16'h0F10);
      applyStimulus(16'h01EF, 16'h3000, 16'h0F00);
      repeat (3) @(negedge clk);
      pop_mask = 16'hFFFF;
      sp       = 16'h5555;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      waitDone("popr", 100, cyc);

      // Address and SP wrap.
      $display("[TB] address wrap");
      addrQ.push_back(20'h0FFEE);
      rdataQ.push_back(16'h5555);
      pushWrite(STACK_IDX_AW, 16'h5555);
      spQ.push_back(16'h0000);
      applyStimulus(STACK_AW, 16'hFFFF, 16'hFFFE);
      waitDone("wrap", 50, cyc);

      // Popping SP redirects the following reads.
      $display("[TB] SP reload");
      addrQ.push_back(20'h00100);
      addrQ.push_back(20'h00800);
      rdataQ.push_back(16'h0800);
      rdataQ.push_back(16'h1111);
      pushWrite(STACK_IDX_SP, 16'h0800);
      pushWrite(STACK_IDX_AW, 16'h1111);
      spQ.push_back(16'h0802);
      applyStimulus(STACK_SP | STACK_AW, 16'h0000, 16'h0100);
      waitDone("spload", 50, cyc);

      // Popping SS redirects the following reads.
      $display("[TB] SS reload");
      addrQ.push_back(20'h10010);
      addrQ.push_back(20'h20012);
      rdataQ.push_back(16'h2000);
      rdataQ.push_back(16'h7777);
      pushWrite(STACK_IDX_SS, 16'h2000);
      pushWrite(STACK_IDX_AW, 16'h7777);
      spQ.push_back(16'h0014);
      applyStimulus(STACK_SS | STACK_AW, 16'h1000, 16'h0010);
      waitDone("ssload", 50, cyc);

      // Empty mask: no reads, done two cycles after start.
      $display("[TB] empty mask");
      spQ.push_back(16'h4242);
      applyStimulus(16'h0000, 16'h1000, 16'h4242);
      waitDone("empty", 20, cyc);
      checkOutput("empty_done_latency", 32'(cyc + 1), 32'd2);

      // Slow ack with reset pulsed during READ.
      $display("[TB] reset during read");
      ackWait = 5;
      addrQ.push_back(20'h10100);
      rdataQ.push_back(16'hBEEF);
      applyStimulus(STACK_AW, 16'h1000, 16'h0100);
      for (int n = 0; n < 20; n++) begin
         if (mem_req) break;
         @(negedge clk);
      end
      checkOutput("slow_req_seen", 32'(mem_req), 32'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
      checkOutput("rst_sp_wr", 32'(sp_wr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      #2;
      checkOutput("rst_reads_left", 32'(addrQ.size()), 32'd0);
      checkOutput("rst_idle_busy", 32'(busy), 32'd0);
      rdataQ.delete();
      ackWait = 0;

`ifdef STACK_POP_ABORT_EN
      // Abort coinciding with mem_ack: no write, no done.
      $display("[TB] abort with ack");
      ackWait = 2;
      addrQ.push_back(20'h10100);
      rdataQ.push_back(16'hCAFE);
      applyStimulus(STACK_AW, 16'h1000, 16'h0100);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         #1;
         if (mem_ack) begin
            abort = 1'b1;
            break;
         end
      end
      checkOutput("abort_ack_seen", 32'(mem_ack), 32'd1);
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      #2;
      checkOutput("abort_reads_left", 32'(addrQ.size()), 32'd0);
      rdataQ.delete();
      ackWait = 0;
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
